// File: rtl/streaming_pooling_unit_pkg.sv
// Shared definitions for the streaming pooling unit: lane-slice macros,
// pooling mode encoding and a constant log2 helper.
`ifndef STREAMING_POOLING_UNIT_PKG_SV
`define STREAMING_POOLING_UNIT_PKG_SV

`define SPU_L(c, w) (((c) + 1) * (w) - 1)
`define SPU_R(c, w) ((c) * (w))

package streaming_pooling_unit_pkg;

  typedef enum logic {
    POOL_MODE_MAX = 1'b0,
    POOL_MODE_AVG = 1'b1
  } pool_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >> 1) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/streaming_pooling_unit_lane.sv
// One pooling lane: accumulator plus compare/add datapath and the final
// averaging shift. The result is formed from the post-update accumulator.
module pool_lane
  import streaming_pooling_unit_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int WINDOW  = 4,
  parameter int SIGNED  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic               first,
  input  pool_mode_e         mode,
  input  logic [D_WIDTH-1:0] elem,
  output logic [D_WIDTH-1:0] result
);

  localparam int SHIFT   = clog2(WINDOW);
  localparam int A_WIDTH = D_WIDTH + SHIFT;

  logic [A_WIDTH-1:0] acc_r;
  logic [A_WIDTH-1:0] ext_s;
  logic [A_WIDTH-1:0] acc_next_s;
  logic [D_WIDTH-1:0] shifted_s;
  logic               greater_s;

  // Widen the element and compare it against the running value.
  always_comb begin
    ext_s     = '0;
    greater_s = 1'b0;
    if (SIGNED != 0) begin
      ext_s     = {{SHIFT{elem[D_WIDTH-1]}}, elem};
      greater_s = $signed(ext_s) > $signed(acc_r);
    end else begin
      ext_s     = {{SHIFT{1'b0}}, elem};
      greater_s = ext_s > acc_r;
    end
  end

  // Next accumulator value; ties in max mode keep the stored value.
  always_comb begin
    acc_next_s = acc_r;
    if (first) begin
      acc_next_s = ext_s;
    end else if (mode == POOL_MODE_AVG) begin
      acc_next_s = acc_r + ext_s;
    end else if (greater_s) begin
      acc_next_s = ext_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Window result: divide by WINDOW (floor) in average mode, raw value in max mode.
  always_comb begin
    shifted_s = '0;
    result    = '0;
    if (SIGNED != 0) begin
      shifted_s = D_WIDTH'($signed(acc_next_s) >>> SHIFT);
    end else begin
      shifted_s = D_WIDTH'(acc_next_s >> SHIFT);
    end
    if (mode == POOL_MODE_AVG) begin
      result = shifted_s;
    end else begin
      result = acc_next_s[D_WIDTH-1:0];
    end
  end

  // Accumulator register; a flush drops the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (load) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/streaming_pooling_unit.sv
// Multi-channel streaming pooling engine: reduces every WINDOW input beats to
// one max or average result per lane, with valid/ready on both sides.
module streaming_pooling_unit
  import streaming_pooling_unit_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int D_WIDTH  = 16,
  parameter int WINDOW   = 4,
  parameter int SIGNED   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*D_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*D_WIDTH-1:0] out_data
);

  localparam int CW = clog2(WINDOW);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WINDOW - 1);

  logic [CW-1:0]               cnt_r;
  pool_mode_e                  mode_r;
  pool_mode_e                  mode_eff_s;
  logic                        out_valid_r;
  logic [CHANNELS*D_WIDTH-1:0] out_data_r;
  logic [CHANNELS*D_WIDTH-1:0] results_s;
  logic                        in_fire_s;
  logic                        out_fire_s;
  logic                        first_s;
  logic                        last_s;

  // Ready frees up in the same cycle the held result drains.
  assign in_ready  = !out_valid_r || out_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Handshake decode; a flush cycle swallows any input beat.
  always_comb begin
    in_fire_s  = in_valid && in_ready && !clear;
    out_fire_s = out_valid_r && out_ready;
    first_s    = (cnt_r == '0);
    last_s     = in_fire_s && (cnt_r == LAST_BEAT);
    if (first_s) begin
      mode_eff_s = pool_mode_e'(mode);
    end else begin
      mode_eff_s = mode_r;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pool_lane #(
      .D_WIDTH(D_WIDTH),
      .WINDOW (WINDOW),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .load  (in_fire_s),
      .first (first_s),
      .mode  (mode_eff_s),
      .elem  (in_data[`SPU_L(g, D_WIDTH):`SPU_R(g, D_WIDTH)]),
      .result(results_s[`SPU_L(g, D_WIDTH):`SPU_R(g, D_WIDTH)])
    );
  end

  // Beat counter, mode latch and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      mode_r      <= POOL_MODE_MAX;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (clear) begin
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (in_fire_s) begin
        if (last_s) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1'b1);
        end
        if (first_s) begin
          mode_r <= mode_eff_s;
        end
      end
      if (last_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= results_s;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_streaming_pooling_unit.sv
// Directed bench: an unsigned and a signed instance share one stimulus stream;
// expected values are hand-computed per window.
module tb_streaming_pooling_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        mode;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        u_in_ready, u_out_valid;
  logic [15:0] u_out_data;
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_data;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]  b2b_l0  [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd5, 8'd5, 8'd5};
  logic [15:0] b2b_exp [3]  = '{16'h1004, 16'h2009, 16'h3005};

  always #5 clk = ~clk;

  streaming_pooling_unit #(.CHANNELS(2), .D_WIDTH(8), .WINDOW(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data)
  );

  streaming_pooling_unit #(.CHANNELS(2), .D_WIDTH(8), .WINDOW(4), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] l0, input logic [7:0] l1, input logic m);
    in_valid = 1'b1;
    in_data  = {l1, l0};
    mode     = m;
    tick();
  endtask

  initial begin
    rst_n     = 1'b1;
    clear     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = 16'h0000;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, u_out_valid}, 32'd0);
    check("reset_out_data", {16'd0, u_out_data}, 32'h0000);
    check("reset_in_ready", {31'd0, u_in_ready}, 32'd1);
    check("reset_s_in_ready", {31'd0, s_in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Unsigned max: lane0 3,9,2,7 ; lane1 0,0,255,1
    beat(8'd3, 8'd0, 1'b0);
    beat(8'd9, 8'd0, 1'b0);
    beat(8'd2, 8'd255, 1'b0);
    beat(8'd7, 8'd1, 1'b0);
    in_valid = 1'b0;
    check("max_out_valid", {31'd0, u_out_valid}, 32'd1);
    check("max_unsigned_data", {16'd0, u_out_data}, 32'h0000ff09);
    check("max_signed_data", {16'd0, s_out_data}, 32'h00000109);
    tick();
    check("drain_out_valid", {31'd0, u_out_valid}, 32'd0);
    check("drain_data_retained", {16'd0, u_out_data}, 32'h0000ff09);

    // Average: lane0 -3,-2,0,0 ; lane1 10,10,10,11
    beat(8'hfd, 8'd10, 1'b1);
    beat(8'hfe, 8'd10, 1'b1);
    beat(8'h00, 8'd10, 1'b1);
    beat(8'h00, 8'd11, 1'b1);
    in_valid = 1'b0;
    check("avg_s_out_valid", {31'd0, s_out_valid}, 32'd1);
    check("avg_signed_data", {16'd0, s_out_data}, 32'h00000afe);
    check("avg_unsigned_data", {16'd0, u_out_data}, 32'h00000a7e);
    tick();

    // Backpressure: result held while out_ready is low, counter frozen
    out_ready = 1'b0;
    beat(8'd1, 8'd8, 1'b0);
    beat(8'd2, 8'd7, 1'b0);
    beat(8'd3, 8'd6, 1'b0);
    beat(8'd4, 8'd5, 1'b0);
    check("bp_out_valid", {31'd0, u_out_valid}, 32'd1);
    check("bp_data", {16'd0, u_out_data}, 32'h00000804);
    in_valid = 1'b1;
    in_data  = {8'd3, 8'd10};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", {16'd0, u_out_data}, 32'h00000804);
      check("bp_in_ready_low", {31'd0, u_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, u_in_ready}, 32'd1);
    tick();
    check("bp_release_drained", {31'd0, u_out_valid}, 32'd0);
    beat(8'd12, 8'd1, 1'b0);
    beat(8'd11, 8'd2, 1'b0);
    check("bp_counter_frozen", {31'd0, u_out_valid}, 32'd0);
    beat(8'd5, 8'd0, 1'b0);
    check("bp_next_valid", {31'd0, u_out_valid}, 32'd1);
    check("bp_next_data", {16'd0, u_out_data}, 32'h0000030c);

    // Back-to-back windows with continuous in_valid
    for (int i = 0; i < 12; i++) begin
      beat(b2b_l0[i], 8'(8'h10 * (i / 4 + 1)), 1'b0);
      check("b2b_out_valid", {31'd0, u_out_valid}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      if ((i % 4) == 3) begin
        check("b2b_data", {16'd0, u_out_data}, {16'd0, b2b_exp[i / 4]});
      end
    end

    // Mode changes mid-window are ignored until the next first beat
    beat(8'd1, 8'd0, 1'b0);
    beat(8'd5, 8'd0, 1'b1);
    beat(8'd4, 8'd0, 1'b1);
    beat(8'd2, 8'd8, 1'b1);
    check("mode_latch_max", {16'd0, u_out_data}, 32'h00000805);
    beat(8'd4, 8'd1, 1'b1);
    beat(8'd4, 8'd2, 1'b1);
    beat(8'd8, 8'd3, 1'b1);
    beat(8'd8, 8'd6, 1'b1);
    check("mode_next_avg", {16'd0, u_out_data}, 32'h00000306);
    in_valid = 1'b0;

    // Flush after two beats; the beat offered during clear is discarded
    beat(8'd200, 8'd200, 1'b0);
    beat(8'd200, 8'd200, 1'b0);
    clear   = 1'b1;
    in_data = {8'd250, 8'd250};
    tick();
    clear = 1'b0;
    check("clear_out_valid", {31'd0, u_out_valid}, 32'd0);
    beat(8'd1, 8'd7, 1'b1);
    beat(8'd2, 8'd7, 1'b1);
    beat(8'd3, 8'd7, 1'b1);
    check("clear_no_early_result", {31'd0, u_out_valid}, 32'd0);
    beat(8'd4, 8'd7, 1'b1);
    check("clear_fresh_valid", {31'd0, u_out_valid}, 32'd1);
    check("clear_fresh_data", {16'd0, u_out_data}, 32'h00000702);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("held_before_clear", {31'd0, u_out_valid}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_drops_held", {31'd0, u_out_valid}, 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a window
    beat(8'd9, 8'd9, 1'b0);
    beat(8'd9, 8'd9, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, u_out_valid}, 32'd0);
    check("midreset_out_data", {16'd0, u_out_data}, 32'h0000);
    check("midreset_s_out_data", {16'd0, s_out_data}, 32'h0000);
    check("midreset_in_ready", {31'd0, u_in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    beat(8'd3, 8'd6, 1'b0);
    beat(8'd3, 8'd6, 1'b0);
    check("post_reset_counter", {31'd0, u_out_valid}, 32'd0);
    beat(8'd3, 8'd6, 1'b0);
    beat(8'd3, 8'd6, 1'b0);
    in_valid = 1'b0;
    check("post_reset_data", {16'd0, u_out_data}, 32'h00000603);
    check("post_reset_valid", {31'd0, u_out_valid}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/streaming_pooling_unit.md
Name: streaming_pooling_unit

Overview:
Sequential, multi-channel pooling engine for the pooling layer. Accepts one element per channel per beat over a valid/ready stream, and reduces every WINDOW consecutive beats to one result per channel. Supports max mode and average mode, signed or unsigned data. Sits between the convolution output stream and the pooling-layer output buffer, with full backpressure support.

Parameters:
CHANNELS, 4, number of independent lanes processed in parallel
D_WIDTH, 16, bits per element per lane
WINDOW, 4, beats reduced per result; power of two, >= 2
SIGNED, 0, 1 = two's-complement compare and average; 0 = unsigned

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
clear  in  1  synchronous flush; discards the partial window and any held output
mode  in  1  0 = max, 1 = average; sampled on the first beat of each window
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept an input beat
in_data  in  CHANNELS*D_WIDTH  lane c at bits [(c+1)*D_WIDTH-1 : c*D_WIDTH]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  CHANNELS*D_WIDTH  per-lane result, same packing as in_data

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, beat counter=0, latched mode=0, accumulators=0. in_ready=1 once out_valid=0.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational and allows the next window to proceed in the same cycle the held result drains.
- Beat counter: width clog2(WINDOW). Increments on each input handshake. Wraps from WINDOW-1 to 0.
- First beat (counter==0):
  - Latch mode.
  - Max mode: accumulator = in_data lane.
  - Average mode: accumulator = sign- or zero-extended in_data lane.
- Later beats:
  - Max mode: accumulator = larger of accumulator and element. Compare is signed when SIGNED=1. Ties keep the accumulator.
  - Average mode: accumulator += extended element.
- Accumulator width: D_WIDTH + clog2(WINDOW). No overflow is possible.
- Final beat (counter==WINDOW-1, handshake): next cycle out_valid=1 and out_data=result. The result includes the final beat's data.
  - Max result: low D_WIDTH bits of the accumulator.
  - Average result: sum >> clog2(WINDOW). Arithmetic shift when SIGNED=1, so it rounds toward -infinity; logical shift when SIGNED=0.
- Latency: 1 cycle from the final-beat handshake to out_valid. Throughput is 1 beat/cycle when out_ready is held high.
- out_valid and out_data hold stable until the output handshake. out_data is not altered while out_valid=1 and out_ready=0.
- Output handshake without a simultaneous final beat: out_valid -> 0 next cycle. out_data retains its last value.
- Simultaneous output handshake and final-beat input handshake: out_valid stays 1 and out_data loads the new result. No bubble.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. The counter and accumulators freeze.
- in_valid=0 mid-window: state holds indefinitely. Gaps are allowed between beats.
- mode changes mid-window: ignored until the next first beat.
- clear=1: next cycle counter=0 and out_valid=0. Any input handshake in that cycle is discarded. clear overrides all other events.
- rst_n asserted mid-window: immediate return to the reset state. The partial window is lost.
- Each lane is independent. The per-lane max (not a joint max) appears at each lane position.

Decomposition:
- Shared definitions header, next to the existing lane-slice L/R macros, holds:
  - POOL_MODE_MAX = 1'b0 and POOL_MODE_AVG = 1'b1.
  - clog2 constant function.
- One sub-module, pool_lane: per-channel accumulator, compare/add datapath and final shift, with parameters D_WIDTH, WINDOW and SIGNED.
- The top holds the counter, mode latch, handshake logic and output register, and instantiates CHANNELS pool_lane instances via generate.

Test Plan:
- Unsigned max, CHANNELS=2, D_WIDTH=8, WINDOW=4. Lane0 beats 3,9,2,7; lane1 beats 0,0,255,1; out_ready=1 -> one cycle after beat 4: out_valid=1, out_data lane0=9, lane1=255.
- Signed average, SIGNED=1, mode=1, D_WIDTH=8, WINDOW=4. Lane0 beats -3,-2,0,0 (sum -5) -> lane0=-2 (0xFE). Lane1 beats 10,10,10,11 -> lane1=10.
- Backpressure: out_ready=0 for 5 cycles after the result -> out_data stable, in_ready=0, counter frozen. Raising out_ready -> in_ready=1 in the same cycle.
- Back-to-back windows: continuous in_valid with out_ready=1 for 3 windows -> out_valid pulses every 4 cycles with no lost beats. Drain and final-beat coincidence updates out_data without a bubble.
- Mode change mid-window: mode=0 on beat 0, mode=1 on beats 1-3, lane0 beats 1,5,4,2 -> result 5 (max). The next window uses mode=1.
- Flush and reset: clear after 2 beats, then 4 fresh beats -> the result uses only the fresh beats. rst_n low mid-window -> out_valid=0 and out_data=0 immediately, in_ready=1.
